// File: rtl/csa9_operand_sequencer_if.sv
// Bundle of the operand stream, adder bank and result stream for csa9_operand_sequencer.
// chk_err is present only when CSA9_SELF_CHECK_EN is defined.
interface csa9_operand_sequencer_if;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic         in_last;
  logic         flush;
  logic [143:0] op_bus;
  logic [19:0]  adder_sum;
  logic         out_valid;
  logic         out_ready;
  logic [19:0]  out_sum;
  logic [3:0]   out_count;
`ifdef CSA9_SELF_CHECK_EN
  logic         chk_err;

  modport master (
    output in_valid, in_data, in_last, flush, adder_sum, out_ready,
    input  in_ready, op_bus, out_valid, out_sum, out_count, chk_err
  );

  modport slave (
    input  in_valid, in_data, in_last, flush, adder_sum, out_ready,
    output in_ready, op_bus, out_valid, out_sum, out_count, chk_err
  );
`else
  modport master (
    output in_valid, in_data, in_last, flush, adder_sum, out_ready,
    input  in_ready, op_bus, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, flush, adder_sum, out_ready,
    output in_ready, op_bus, out_valid, out_sum, out_count
  );
`endif
endinterface

// File: rtl/csa9_operand_sequencer.sv
// Streams up to 9 operands into a stable bank for the external CSA tree, waits SETTLE_CYCLES
// (1..15), then captures and hands off the sum. CSA9_SELF_CHECK_EN adds a sticky sum check.
module csa9_operand_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  csa9_operand_sequencer_if.slave   bus
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {StFill, StSettle, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  ctr_q, ctr_d;
  logic [15:0] slot_q [9];
  logic [15:0] slot_d [9];
  logic        out_valid_q, out_valid_d;
  logic [19:0] out_sum_q, out_sum_d;
  logic [3:0]  out_count_q, out_count_d;
  logic        init_q;
  logic        in_ready;
  logic        accept;
  logic        capture;

  // init_q keeps in_ready low until the first clock after reset release.
  assign in_ready = init_q && (state_q == StFill);
  assign accept   = bus.in_valid && in_ready && !bus.flush;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ctr_d       = ctr_q;
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    capture     = 1'b0;

    if (bus.flush) begin
      state_d     = StFill;
      cnt_d       = 4'd0;
      ctr_d       = 4'd0;
      out_valid_d = 1'b0;
      for (int k = 0; k < 9; k++) slot_d[k] = 16'd0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (accept) begin
            for (int k = 0; k < 9; k++) begin
              if (cnt_q == 4'(k)) slot_d[k] = bus.in_data;
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd8 || bus.in_last) begin
              state_d     = StSettle;
              ctr_d       = SettleLoad;
              out_count_d = cnt_q + 4'd1;
            end
          end
        end
        StSettle: begin
          if (ctr_q == 4'd0) begin
            capture     = 1'b1;
            out_sum_d   = bus.adder_sum;
            out_valid_d = 1'b1;
            state_d     = StDone;
          end else begin
            ctr_d = ctr_q - 4'd1;
          end
        end
        StDone: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            cnt_d       = 4'd0;
            state_d     = StFill;
            for (int k = 0; k < 9; k++) slot_d[k] = 16'd0;
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      cnt_q       <= 4'd0;
      ctr_q       <= 4'd0;
      out_valid_q <= 1'b0;
      out_sum_q   <= 20'd0;
      out_count_q <= 4'd0;
      init_q      <= 1'b0;
      for (int k = 0; k < 9; k++) slot_q[k] <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ctr_q       <= ctr_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      init_q      <= 1'b1;
      slot_q      <= slot_d;
    end
  end

  always_comb begin
    bus.op_bus = '0;
    for (int k = 0; k < 9; k++) bus.op_bus[16*k +: 16] = slot_q[k];
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;

`ifdef CSA9_SELF_CHECK_EN
  logic [19:0] ref_sum;
  logic        chk_err_q, chk_err_d;

  always_comb begin
    ref_sum = 20'd0;
    for (int k = 0; k < 9; k++) ref_sum = ref_sum + 20'(slot_q[k]);
  end

  always_comb begin
    chk_err_d = chk_err_q;
    if (bus.flush) begin
      chk_err_d = 1'b0;
    end else if (capture && (bus.adder_sum != ref_sum)) begin
      chk_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_err_q <= 1'b0;
    else        chk_err_q <= chk_err_d;
  end

  assign bus.chk_err = chk_err_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_csa9_operand_sequencer.sv
// Directed bench for csa9_operand_sequencer: a queue of expected results is filled by the
// stimulus and drained by a monitor at every accepted output.
module tb_csa9_operand_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flip = 1'b0;
  logic [19:0] model_sum;

  csa9_operand_sequencer_if bus ();

  csa9_operand_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Adder model; flip corrupts bit 5 for the self-check scenario.
  always_comb begin
    model_sum = 20'd0;
    for (int k = 0; k < 9; k++) model_sum = model_sum + 20'(bus.op_bus[16*k +: 16]);
    bus.adder_sum = flip ? (model_sum ^ 20'h00020) : model_sum;
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q [$];

  function automatic void check(string name, logic [143:0] act, logic [143:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void push_exp(logic [19:0] sum, logic [3:0] count);
    exp_q.push_back({count, sum});
  endfunction

  // Monitor: every accepted result is matched against the oldest expectation.
  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got sum 0x%0h count %0d, none expected",
                 bus.out_sum, bus.out_count);
      end else begin
        e = exp_q.pop_front();
        check("result_sum", 144'(bus.out_sum), 144'(e[19:0]));
        check("result_count", 144'(bus.out_count), 144'(e[23:20]));
      end
    end
  end

  // Presents one beat from the drive point (1 ns after a rising edge) until accepted.
  task automatic send(input logic [15:0] d, input logic l);
    int g = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready 0 after %0d cycles, expected 1", g);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Returns on the falling edge where out_valid is first seen high.
  task automatic wait_out_valid();
    int g = 0;
    @(negedge clk);
    while (!bus.out_valid && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (!bus.out_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL out_valid_timeout: out_valid 0 after %0d cycles, expected 1", g);
    end
  endtask

  task automatic realign();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'd0;
    bus.in_last   = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 144'(bus.in_ready), 144'd0);
    check("rst_out_valid", 144'(bus.out_valid), 144'd0);
    check("rst_out_sum", 144'(bus.out_sum), 144'd0);
    check("rst_out_count", 144'(bus.out_count), 144'd0);
    check("rst_op_bus", bus.op_bus, 144'd0);
`ifdef CSA9_SELF_CHECK_EN
    check("rst_chk_err", 144'(bus.chk_err), 144'd0);
`endif
    rst_n = 1'b1;
    #1;
    check("in_ready_before_first_clk", 144'(bus.in_ready), 144'd0);
    realign();
    check("in_ready_after_release", 144'(bus.in_ready), 144'd1);

    // Full frame of 0xFFFF, latency and ready return
    for (int i = 0; i < 9; i++) send(16'hFFFF, 1'b0);
    push_exp(20'h8FFF7, 4'd9);
    @(negedge clk);
    check("full_valid_c1", 144'(bus.out_valid), 144'd0);
    check("full_ready_c1", 144'(bus.in_ready), 144'd0);
    @(negedge clk);
    check("full_valid_c2", 144'(bus.out_valid), 144'd0);
    @(negedge clk);
    check("full_valid_c3", 144'(bus.out_valid), 144'd1);
    check("full_ready_c3", 144'(bus.in_ready), 144'd0);
    @(negedge clk);
    check("full_ready_return", 144'(bus.in_ready), 144'd1);
    check("full_valid_drop", 144'(bus.out_valid), 144'd0);
    check("full_bank_cleared", bus.op_bus, 144'd0);
    realign();

    // Short frame, zero padding
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    send(16'd3, 1'b1);
    push_exp(20'd6, 4'd3);
    check("short_upper_slots", 144'(bus.op_bus[143:48]), 144'd0);
    check("short_lower_slots", 144'(bus.op_bus[47:0]), 144'h0003_0002_0001);
    wait_out_valid();
    realign();

    // Backpressure: result held, input ignored
    bus.out_ready = 1'b0;
    send(16'd5, 1'b0);
    send(16'd7, 1'b1);
    push_exp(20'd12, 4'd2);
    wait_out_valid();
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hABCD;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 144'(bus.out_valid), 144'd1);
      check("bp_sum", 144'(bus.out_sum), 144'd12);
      check("bp_count", 144'(bus.out_count), 144'd2);
      check("bp_in_ready", 144'(bus.in_ready), 144'd0);
      check("bp_bank", 144'(bus.op_bus[31:0]), 144'h0007_0005);
    end
    realign();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    realign();
    check("bp_bank_cleared", bus.op_bus, 144'd0);
    check("bp_ready_back", 144'(bus.in_ready), 144'd1);

    // Flush mid-fill with a simultaneous beat
    send(16'd100, 1'b0);
    send(16'd200, 1'b0);
    send(16'd300, 1'b0);
    send(16'd400, 1'b0);
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd500;
    #2;
    check("flush_in_ready", 144'(bus.in_ready), 144'd1);
    realign();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_bank", bus.op_bus, 144'd0);
    check("flush_out_sum_kept", 144'(bus.out_sum), 144'd12);
    check("flush_out_count_kept", 144'(bus.out_count), 144'd2);
    for (int i = 0; i < 9; i++) send(16'd1, 1'b0);
    push_exp(20'd9, 4'd9);
    wait_out_valid();
    realign();

    // in_last on the first beat
    send(16'h1234, 1'b1);
    push_exp(20'h01234, 4'd1);
    wait_out_valid();
    realign();

    // in_last on the ninth beat
    for (int i = 1; i <= 9; i++) send(16'(i), (i == 9));
    push_exp(20'd45, 4'd9);
    wait_out_valid();
    realign();

    // Async reset during SETTLE
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 144'(bus.out_valid), 144'd0);
    check("arst_op_bus", bus.op_bus, 144'd0);
    check("arst_in_ready", 144'(bus.in_ready), 144'd0);
    check("arst_out_count", 144'(bus.out_count), 144'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    realign();
    check("arst_ready_after", 144'(bus.in_ready), 144'd1);
    send(16'd10, 1'b0);
    send(16'd20, 1'b1);
    push_exp(20'd30, 4'd2);
    wait_out_valid();
    realign();

`ifdef CSA9_SELF_CHECK_EN
    // Faulty adder: chk_err sets at capture, sticks, clears on flush
    flip = 1'b1;
    send(16'd1, 1'b0);
    send(16'd2, 1'b1);
    push_exp(20'd35, 4'd2);
    check("chk_before_capture", 144'(bus.chk_err), 144'd0);
    wait_out_valid();
    check("chk_at_capture", 144'(bus.chk_err), 144'd1);
    realign();
    check("chk_sticky", 144'(bus.chk_err), 144'd1);
    flip = 1'b0;
    bus.flush = 1'b1;
    realign();
    bus.flush = 1'b0;
    check("chk_flush_clear", 144'(bus.chk_err), 144'd0);
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 144'(exp_q.size()), 144'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
